// File: rtl/accel_pkg.sv
// Shared accelerator types: lane counts, psum/pixel types and the collector state encoding.
package accel_pkg;

    localparam int unsigned PARALLEL_OFM = 2;
    localparam int unsigned PARALLEL_IFM = 2;
    localparam int unsigned PSUM_W       = 20;
    localparam int unsigned PIX_W        = 8;

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic signed [PIX_W-1:0]  pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } collector_state_e;

endpackage

// File: rtl/psum_lane_accum.sv
// One output-channel lane: per-column accumulator file with overwrite/add write port and a
// quantize+saturate read port that looks at the next-state contents.
module psum_lane_accum #(
    parameter int unsigned ACC_WIDTH   = 20,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COLS        = 3,
    parameter int unsigned QUANT_SHIFT = 4,
    parameter int unsigned COL_W       = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic                  wr_first_i,
    input  logic [COL_W-1:0]      wr_col_i,
    input  logic [ACC_WIDTH-1:0]  wr_psum_i,
    input  logic [COL_W-1:0]      rd_col_i,
    output logic [DATA_WIDTH-1:0] rd_pix_c_o
);

    localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] PIX_MIN = -PIX_MAX - ACC_WIDTH'(1);

    logic [ACC_WIDTH-1:0]        acc_q [COLS];
    logic [ACC_WIDTH-1:0]        acc_d [COLS];
    logic signed [ACC_WIDTH-1:0] rd_acc;
    logic signed [ACC_WIDTH-1:0] rd_shift;

    // Pass 0 overwrites, so the file needs no reset; later passes add with natural wrap.
    always_comb begin
        acc_d = acc_q;
        if (wr_en_i) begin
            acc_d[wr_col_i] = wr_first_i ? wr_psum_i : acc_q[wr_col_i] + wr_psum_i;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    // Reading next-state contents lets the registered output see a same-edge final write.
    always_comb begin
        rd_acc   = acc_d[rd_col_i];
        rd_shift = rd_acc >>> QUANT_SHIFT;
        if (rd_shift > PIX_MAX) begin
            rd_pix_c_o = DATA_WIDTH'(PIX_MAX);
        end else if (rd_shift < PIX_MIN) begin
            rd_pix_c_o = DATA_WIDTH'(PIX_MIN);
        end else begin
            rd_pix_c_o = DATA_WIDTH'(rd_shift);
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Collects column partial sums from the PE array, accumulates them over IFM passes and
// drains the quantized OFM row over valid/ready while stalling the feeder.
module psum_collector #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH    = 20,
    parameter int unsigned ROW_WIDTH    = 5,
    parameter int unsigned KERNEL_WIDTH = 3,
    parameter int unsigned PARALLEL_OFM = 2,
    parameter int unsigned QUANT_SHIFT  = 4
) (
    input  logic                                    clk,
    input  logic                                    arst_n,
    input  logic                                    start,
    input  logic [7:0]                              ifm_passes,
    input  logic                                    pe_valid,
    input  logic [PARALLEL_OFM-1:0][ACC_WIDTH-1:0]  pe_psum,
    input  logic [PARALLEL_OFM-1:0]                 pofm_active,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [PARALLEL_OFM-1:0][DATA_WIDTH-1:0] out_data,
    output logic                                    out_last,
    output logic                                    processing_stall,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    proto_err
);

    import accel_pkg::collector_state_e;
    import accel_pkg::IDLE;
    import accel_pkg::ACCUM;
    import accel_pkg::DRAIN;

    localparam int unsigned OUT_COLS = ROW_WIDTH - KERNEL_WIDTH + 1;
    localparam int unsigned COL_W    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

    collector_state_e                        state_q, state_d;
    logic [7:0]                              pass_q, pass_d;
    logic [7:0]                              passes_q, passes_d;
    logic [COL_W-1:0]                        col_q, col_d;
    logic [COL_W-1:0]                        drain_q, drain_d;
    logic [PARALLEL_OFM-1:0]                 mask_q, mask_d;
    logic                                    valid_q, valid_d;
    logic                                    last_q, last_d;
    logic                                    stall_q, stall_d;
    logic                                    busy_q, busy_d;
    logic                                    done_q, done_d;
    logic                                    err_q, err_d;
    logic [PARALLEL_OFM-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [PARALLEL_OFM-1:0][DATA_WIDTH-1:0] lane_pix;
    logic                                    wr_en_c;

    for (genvar l = 0; l < PARALLEL_OFM; l++) begin : g_lane
        psum_lane_accum #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .COLS       (OUT_COLS),
            .QUANT_SHIFT(QUANT_SHIFT),
            .COL_W      (COL_W)
        ) u_lane (
            .clk       (clk),
            .wr_en_i   (wr_en_c && mask_q[l]),
            .wr_first_i(pass_q == 8'd0),
            .wr_col_i  (col_q),
            .wr_psum_i (pe_psum[l]),
            .rd_col_i  (drain_d),
            .rd_pix_c_o(lane_pix[l])
        );
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        passes_d = passes_q;
        col_d    = col_q;
        drain_d  = drain_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        wr_en_c  = 1'b0;
        err_d    = err_q | (pe_valid && (state_q != ACCUM));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACCUM;
                    pass_d   = 8'd0;
                    col_d    = '0;
                    drain_d  = '0;
                    passes_d = (ifm_passes == 8'd0) ? 8'd1 : ifm_passes;
                    mask_d   = pofm_active;
                end
            end
            ACCUM: begin
                if (pe_valid) begin
                    wr_en_c = 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (pass_q == passes_q - 8'd1) begin
                            state_d = DRAIN;
                            drain_d = '0;
                        end else begin
                            pass_d = pass_q + 8'd1;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (drain_q == LAST_COL) begin
                        state_d = IDLE;
                        drain_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + COL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == DRAIN);
        stall_d = (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
        last_d  = valid_d && (drain_d == LAST_COL);
        for (int l = 0; l < PARALLEL_OFM; l++) begin
            data_d[l] = (valid_d && mask_d[l]) ? lane_pix[l] : '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            pass_q   <= '0;
            passes_q <= '0;
            col_q    <= '0;
            drain_q  <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            stall_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            passes_q <= passes_d;
            col_q    <= col_d;
            drain_q  <= drain_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            stall_q  <= stall_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_last         = last_q;
    assign out_data         = data_q;
    assign processing_stall = stall_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign proto_err        = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: accumulation, quantization, back-pressure, lane masking,
// protocol errors and reset recovery with hand-computed expected pixels.
module tb_psum_collector;

    localparam int unsigned P  = 2;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 start;
    logic [7:0]           ifm_passes;
    logic                 pe_valid;
    logic [P-1:0][AW-1:0] pe_psum;
    logic [P-1:0]         pofm_active;
    logic                 out_valid;
    logic                 out_ready;
    logic [P-1:0][DW-1:0] out_data;
    logic                 out_last;
    logic                 processing_stall;
    logic                 busy;
    logic                 done;
    logic                 proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psum_collector dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .start           (start),
        .ifm_passes      (ifm_passes),
        .pe_valid        (pe_valid),
        .pe_psum         (pe_psum),
        .pofm_active     (pofm_active),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .processing_stall(processing_stall),
        .busy            (busy),
        .done            (done),
        .proto_err       (proto_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input logic [7:0] np, input logic [1:0] m);
        start       = 1'b1;
        ifm_passes  = np;
        pofm_active = m;
        tick();
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        chk1("stall_in_accum", processing_stall, 1'b0);
    endtask

    task automatic feed(input int a0, input int a1);
        pe_valid   = 1'b1;
        pe_psum[0] = 20'(a0);
        pe_psum[1] = 20'(a1);
        tick();
        pe_valid = 1'b0;
        pe_psum  = '0;
    endtask

    // Drains three beats with out_ready high; ends in the cycle where done should be high.
    task automatic drain3(input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2);
        int ea[3];
        int eb[3];
        ea = '{a0, a1, a2};
        eb = '{b0, b1, b2};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk1("out_valid", out_valid, 1'b1);
            chk1("stall_drain", processing_stall, 1'b1);
            chk1("out_last", out_last, (i == 2));
            chk8("lane0_pix", out_data[0], 8'(ea[i]));
            chk8("lane1_pix", out_data[1], 8'(eb[i]));
            tick();
        end
        chk1("done_pulse", done, 1'b1);
        chk1("valid_after_row", out_valid, 1'b0);
        chk1("busy_after_row", busy, 1'b0);
    endtask

    initial begin
        arst_n      = 1'b0;
        start       = 1'b0;
        ifm_passes  = 8'd1;
        pe_valid    = 1'b0;
        pe_psum     = '0;
        pofm_active = 2'b11;
        out_ready   = 1'b1;
        tick();
        tick();
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_stall", processing_stall, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", proto_err, 1'b0);
        chk8("rst_data0", out_data[0], 8'd0);
        arst_n = 1'b1;
        tick();

        // Single pass with a gap between beats.
        start_row(8'd1, 2'b11);
        feed(16, 160);
        tick();
        chk1("gap_valid", out_valid, 1'b0);
        feed(32, -160);
        feed(48, 4000);
        drain3(1, 2, 3, 10, -10, 127);
        tick();
        chk1("done_one_cycle", done, 1'b0);

        // Three passes; a start while busy must be ignored.
        start_row(8'd3, 2'b11);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 3; c++) begin
                if (p == 1 && c == 0) begin
                    start      = 1'b1;
                    ifm_passes = 8'd1;
                end
                feed(100, -100);
                start = 1'b0;
            end
            if (p == 0) chk1("no_drain_mid_pass", out_valid, 1'b0);
        end
        drain3(18, 18, 18, -19, -19, -19);
        tick();

        // Saturation and arithmetic-shift boundaries.
        start_row(8'd1, 2'b11);
        feed(4000, 2048);
        feed(-4000, -2049);
        feed(-17, 15);
        drain3(127, -128, -2, 127, -128, 0);
        tick();

        // Back-pressure: hold the first beat for five cycles.
        start_row(8'd1, 2'b11);
        out_ready = 1'b0;
        feed(32, 0);
        feed(64, 0);
        feed(96, 0);
        for (int k = 0; k < 5; k++) begin
            chk1("hold_valid", out_valid, 1'b1);
            chk1("hold_stall", processing_stall, 1'b1);
            chk1("hold_last", out_last, 1'b0);
            chk8("hold_data", out_data[0], 8'd2);
            tick();
        end
        drain3(2, 4, 6, 0, 0, 0);
        tick();

        // Lane 1 disabled: its output must read zero.
        start_row(8'd1, 2'b01);
        feed(16, 800);
        feed(32, 800);
        feed(48, 800);
        drain3(1, 2, 3, 0, 0, 0);
        tick();
        chk1("no_spurious_err", proto_err, 1'b0);

        // pe_valid while idle flags a protocol error and starts nothing.
        pe_valid   = 1'b1;
        pe_psum[0] = 20'(1600);
        tick();
        pe_valid = 1'b0;
        pe_psum  = '0;
        chk1("idle_pe_err", proto_err, 1'b1);
        chk1("idle_pe_busy", busy, 1'b0);
        chk1("idle_pe_valid", out_valid, 1'b0);

        // Reset mid-row discards it; the next row is clean.
        start_row(8'd1, 2'b11);
        feed(16, 16);
        #1;
        arst_n = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_err_clear", proto_err, 1'b0);
        chk1("arst_valid", out_valid, 1'b0);
        tick();
        arst_n = 1'b1;
        tick();
        chk1("arst_no_done", done, 1'b0);
        start_row(8'd1, 2'b11);
        feed(16, -32);
        feed(32, -48);
        feed(48, -64);
        drain3(1, 2, 3, -2, -3, -4);
        tick();

        // Zero passes behaves as one; start accepted in the done cycle.
        start_row(8'd0, 2'b11);
        feed(48, -48);
        feed(48, -48);
        feed(48, -48);
        drain3(3, 3, 3, -3, -3, -3);
        start_row(8'd1, 2'b11);
        chk1("done_cleared", done, 1'b0);
        feed(16, 16);
        feed(16, 16);
        feed(16, 16);
        drain3(1, 1, 1, 1, 1, 1);
        tick();
        chk1("final_done_low", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
